core: RTL and testbench
=======================

Name: core

Overview:
- Minimal RV32I integer execute core, single-cycle, no PC and no instruction memory: one 32-bit instruction is presented per clock on `instr`.
- Contains the decoder, immediate generator, a 32x32 register file and the ALU.
- Executes R-type (opcode 0110011) and I-type ALU (opcode 0010011) instructions, writing the result to rd on the rising clock edge.
- Every internal datapath signal is exported on debug ports for bench visibility.

Parameters:
- None. Data width is fixed at 32 bits; the register file is fixed at 32 entries.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  asynchronous reset, active-low; 0 = reset asserted
- instr  in  32  current instruction
- dbg_rs1  out  5  instr[19:15]
- dbg_rs2  out  5  instr[24:20]
- dbg_rd  out  5  instr[11:7]
- dbg_imm  out  32  decoded immediate
- dbg_alu_op  out  4  ALU operation code
- dbg_reg_write  out  1  register-file write enable
- dbg_alu_src_imm  out  1  1 = ALU operand B is the immediate
- dbg_rs1_data  out  32  register-file read port 1
- dbg_rs2_data  out  32  register-file read port 2
- dbg_alu_b  out  32  ALU operand B after the mux
- dbg_alu_result  out  32  ALU output

Behaviour:
- Register file reset: while rst=0, all 32 registers clear to 0 immediately (asynchronous) and no write occurs.
- Debug outputs have no reset state of their own; they are purely combinational functions of `instr` and register contents.
- Register reads are combinational. x0 always reads 0, and writes to x0 are discarded.
- Register write: on posedge clk with rst=1 and reg_write=1, the register at rd is loaded with alu_result.
  - Latency is 1 cycle: the result is readable by the next instruction.
  - A same-cycle read of rd returns the old value; there is no bypass.
- ALU op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10-15 are unused and produce result 0.
- R-type decode (opcode 0110011):
  - funct7 = 0000000: funct3 000/001/010/011/100/101/110/111 map to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 = 0100000 with funct3 000 is SUB; with funct3 101 it is SRA.
  - For these encodings: alu_src_imm=0, reg_write=1, imm=0.
  - Any other funct7/funct3 combination: reg_write=0.
- I-type decode (opcode 0010011):
  - imm = sign-extended instr[31:20], alu_src_imm=1, reg_write=1.
  - funct3 000/010/011/100/110/111 map to ADDI/SLTI/SLTIU/XORI/ORI/ANDI.
  - funct3 001 is SLLI.
  - funct3 101: SRAI when instr[30]=1, else SRLI.
- Any other opcode: reg_write=0, alu_src_imm=0, imm=0, alu_op=ADD. Register state is unchanged.
- ALU operands: A = rs1_data; B = alu_src_imm ? imm : rs2_data.
- ALU arithmetic:
  - ADD/SUB wrap modulo 2^32.
  - SLT compares signed and SLTU compares unsigned; each yields 0 or 1.
  - Shift amount is B[4:0] only; SRA replicates bit 31.
- Reset mid-stream: asserting rst at any time clears all registers immediately. The first edge after rst returns to 1 performs a normal write.

Test Plan:
- Reset: hold rst=0 for 2 cycles with rst=1 thereafter. Sequence addi x1,x0,5 / addi x2,x1,3 / add x3,x1,x2 / srai x4,x3,1 -> x1=5, x2=8, x3=13, x4=6. During srai: dbg_imm=0x00000401, dbg_alu_b=0x401, dbg_alu_op=7.
- x0 protection: addi x0,x0,7, then add x5,x0,x0 -> dbg_rs1_data=0 and x5=0.
- Signed paths: addi x6,x0,-1 -> x6=0xFFFFFFFF. Then slt x7,x6,x1 -> 1; sltu x8,x6,x1 -> 0; srai x9,x6,31 -> 0xFFFFFFFF; srli x10,x6,28 -> 0xF.
- R-type coverage: with x1=5, x2=8: sub x11,x1,x2 -> 0xFFFFFFFD; xor -> 13; or -> 13; and -> 0; sll x12,x1,x2 -> 0x500.
- Illegal/other opcode: instr=0x00000000 and an R-type with funct7=0000001 -> dbg_reg_write=0 and no register changes.
- Async reset mid-run: drop rst to 0 between clock edges -> all registers read 0 before the next edge. Release rst, then addi x1,x0,5 -> x1=5.

Source files
------------

// File: rtl/core.sv
// Single-cycle RV32I integer execute slice: decoder, immediate generator,
// 32x32 register file and ALU, with every datapath signal exported for debug.
module core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [4:0]  dbg_rs1,
  output logic [4:0]  dbg_rs2,
  output logic [4:0]  dbg_rd,
  output logic [31:0] dbg_imm,
  output logic [3:0]  dbg_alu_op,
  output logic        dbg_reg_write,
  output logic        dbg_alu_src_imm,
  output logic [31:0] dbg_rs1_data,
  output logic [31:0] dbg_rs2_data,
  output logic [31:0] dbg_alu_b,
  output logic [31:0] dbg_alu_result
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic [6:0]  opcode_s;
  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_s;
  logic [3:0]  alu_op_s;
  logic        reg_write_s;
  logic        alu_src_imm_s;
  logic [31:0] rs1_data_s;
  logic [31:0] rs2_data_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_result_s;
  logic [4:0]  shamt_s;
  logic [31:0] regs_r [32];

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_s    = instr[19:15];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];

  // Instruction decode: control signals and immediate
  always_comb begin
    imm_s         = 32'd0;
    alu_op_s      = OP_ADD;
    reg_write_s   = 1'b0;
    alu_src_imm_s = 1'b0;
    case (opcode_s)
      OPC_R: begin
        if (funct7_s == 7'b0000000) begin
          reg_write_s = 1'b1;
          case (funct3_s)
            3'b000:  alu_op_s = OP_ADD;
            3'b001:  alu_op_s = OP_SLL;
            3'b010:  alu_op_s = OP_SLT;
            3'b011:  alu_op_s = OP_SLTU;
            3'b100:  alu_op_s = OP_XOR;
            3'b101:  alu_op_s = OP_SRL;
            3'b110:  alu_op_s = OP_OR;
            3'b111:  alu_op_s = OP_AND;
            default: alu_op_s = OP_ADD;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          case (funct3_s)
            3'b000: begin
              alu_op_s    = OP_SUB;
              reg_write_s = 1'b1;
            end
            3'b101: begin
              alu_op_s    = OP_SRA;
              reg_write_s = 1'b1;
            end
            default: reg_write_s = 1'b0;
          endcase
        end else begin
          reg_write_s = 1'b0;
        end
      end
      OPC_I: begin
        imm_s         = {{20{instr[31]}}, instr[31:20]};
        alu_src_imm_s = 1'b1;
        reg_write_s   = 1'b1;
        case (funct3_s)
          3'b000:  alu_op_s = OP_ADD;
          3'b001:  alu_op_s = OP_SLL;
          3'b010:  alu_op_s = OP_SLT;
          3'b011:  alu_op_s = OP_SLTU;
          3'b100:  alu_op_s = OP_XOR;
          3'b101:  alu_op_s = instr[30] ? OP_SRA : OP_SRL;
          3'b110:  alu_op_s = OP_OR;
          3'b111:  alu_op_s = OP_AND;
          default: alu_op_s = OP_ADD;
        endcase
      end
      default: begin
        imm_s         = 32'd0;
        alu_op_s      = OP_ADD;
        reg_write_s   = 1'b0;
        alu_src_imm_s = 1'b0;
      end
    endcase
  end

  // x0 is hardwired to zero on both read ports
  assign rs1_data_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
  assign rs2_data_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];
  assign alu_b_s    = alu_src_imm_s ? imm_s : rs2_data_s;
  assign shamt_s    = alu_b_s[4:0];

  // ALU
  always_comb begin
    alu_result_s = 32'd0;
    case (alu_op_s)
      OP_ADD:  alu_result_s = rs1_data_s + alu_b_s;
      OP_SUB:  alu_result_s = rs1_data_s - alu_b_s;
      OP_SLL:  alu_result_s = rs1_data_s << shamt_s;
      OP_SLT:  alu_result_s = {31'd0, ($signed(rs1_data_s) < $signed(alu_b_s))};
      OP_SLTU: alu_result_s = {31'd0, (rs1_data_s < alu_b_s)};
      OP_XOR:  alu_result_s = rs1_data_s ^ alu_b_s;
      OP_SRL:  alu_result_s = rs1_data_s >> shamt_s;
      OP_SRA:  alu_result_s = $unsigned($signed(rs1_data_s) >>> shamt_s);
      OP_OR:   alu_result_s = rs1_data_s | alu_b_s;
      OP_AND:  alu_result_s = rs1_data_s & alu_b_s;
      default: alu_result_s = 32'd0;
    endcase
  end

  // Register file write port; reset clears every entry at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (reg_write_s && (rd_s != 5'd0)) begin
      regs_r[rd_s] <= alu_result_s;
    end
  end

  assign dbg_rs1         = rs1_s;
  assign dbg_rs2         = rs2_s;
  assign dbg_rd          = rd_s;
  assign dbg_imm         = imm_s;
  assign dbg_alu_op      = alu_op_s;
  assign dbg_reg_write   = reg_write_s;
  assign dbg_alu_src_imm = alu_src_imm_s;
  assign dbg_rs1_data    = rs1_data_s;
  assign dbg_rs2_data    = rs2_data_s;
  assign dbg_alu_b       = alu_b_s;
  assign dbg_alu_result  = alu_result_s;

endmodule

// File: tb/tb_core.sv
// Directed bench for core: expected values queued at drive time, popped and
// compared against the debug ports shortly before the next rising edge.
module tb_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [4:0]  dbg_rs1, dbg_rs2, dbg_rd;
  logic [31:0] dbg_imm;
  logic [3:0]  dbg_alu_op;
  logic        dbg_reg_write, dbg_alu_src_imm;
  logic [31:0] dbg_rs1_data, dbg_rs2_data, dbg_alu_b, dbg_alu_result;

  core dut (
    .clk(clk), .rst(rst), .instr(instr),
    .dbg_rs1(dbg_rs1), .dbg_rs2(dbg_rs2), .dbg_rd(dbg_rd),
    .dbg_imm(dbg_imm), .dbg_alu_op(dbg_alu_op),
    .dbg_reg_write(dbg_reg_write), .dbg_alu_src_imm(dbg_alu_src_imm),
    .dbg_rs1_data(dbg_rs1_data), .dbg_rs2_data(dbg_rs2_data),
    .dbg_alu_b(dbg_alu_b), .dbg_alu_result(dbg_alu_result)
  );

  always #5 clk = ~clk;

  localparam int S_RES = 0, S_RS1 = 1, S_IMM = 2, S_B = 3, S_OP = 4, S_WE = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RES:   return dbg_alu_result;
      S_RS1:   return dbg_rs1_data;
      S_IMM:   return dbg_imm;
      S_B:     return dbg_alu_b;
      S_OP:    return {28'd0, dbg_alu_op};
      S_WE:    return {31'd0, dbg_reg_write};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.sel = sel;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic check_sb(input int dly);
    #(dly);
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] obs;
      e   = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic run(input logic [31:0] v, input string tag, input logic [31:0] res);
    @(negedge clk);
    instr = v;
    push(tag, S_RES, res);
    check_sb(2);
  endtask

  // add x0, xn, x0 exposes xn on read port 1 without changing state
  task automatic read_reg(input logic [4:0] n, input string tag, input logic [31:0] e);
    @(negedge clk);
    instr = r_type(7'b0000000, 5'd0, n, 3'b000, 5'd0);
    push(tag, S_RS1, e);
    check_sb(2);
  endtask

  initial begin
    // Reset held for two cycles
    #1;
    instr = r_type(7'b0000000, 5'd0, 5'd1, 3'b000, 5'd0);
    push("reset_x1", S_RS1, 32'd0);
    check_sb(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run(i_type(12'd5, 5'd0, 3'b000, 5'd1), "addi_x1", 32'd5);
    @(negedge clk);
    instr = i_type(12'd3, 5'd1, 3'b000, 5'd2);
    push("addi_x2_rs1", S_RS1, 32'd5);
    push("addi_x2", S_RES, 32'd8);
    check_sb(2);
    run(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), "add_x3", 32'd13);
    @(negedge clk);
    instr = i_type(12'h401, 5'd3, 3'b101, 5'd4);
    push("srai_imm", S_IMM, 32'h0000_0401);
    push("srai_b", S_B, 32'h0000_0401);
    push("srai_op", S_OP, 32'd7);
    push("srai_x4", S_RES, 32'd6);
    check_sb(2);
    read_reg(5'd4, "rd_x4", 32'd6);

    // x0 protection
    run(i_type(12'd7, 5'd0, 3'b000, 5'd0), "addi_x0", 32'd7);
    @(negedge clk);
    instr = r_type(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd5);
    push("add_x5_rs1", S_RS1, 32'd0);
    push("add_x5", S_RES, 32'd0);
    check_sb(2);
    read_reg(5'd5, "rd_x5", 32'd0);

    // Signed and unsigned paths
    run(i_type(12'hFFF, 5'd0, 3'b000, 5'd6), "addi_x6", 32'hFFFF_FFFF);
    run(r_type(7'b0000000, 5'd1, 5'd6, 3'b010, 5'd7), "slt_x7", 32'd1);
    run(r_type(7'b0000000, 5'd1, 5'd6, 3'b011, 5'd8), "sltu_x8", 32'd0);
    run(i_type(12'h41F, 5'd6, 3'b101, 5'd9), "srai_x9", 32'hFFFF_FFFF);
    run(i_type(12'd28, 5'd6, 3'b101, 5'd10), "srli_x10", 32'h0000_000F);
    read_reg(5'd7, "rd_x7", 32'd1);
    read_reg(5'd9, "rd_x9", 32'hFFFF_FFFF);
    read_reg(5'd10, "rd_x10", 32'h0000_000F);

    // R-type coverage with x1=5, x2=8
    run(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd11), "sub_x11", 32'hFFFF_FFFD);
    run(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd13), "xor_x13", 32'd13);
    run(r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd14), "or_x14", 32'd13);
    run(r_type(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd15), "and_x15", 32'd0);
    run(r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd12), "sll_x12", 32'h0000_0500);
    run(r_type(7'b0100000, 5'd1, 5'd6, 3'b101, 5'd18), "sra_x18", 32'hFFFF_FFFF);
    run(r_type(7'b0000000, 5'd1, 5'd6, 3'b101, 5'd19), "srl_x19", 32'h07FF_FFFF);
    run(i_type(12'd4, 5'd1, 3'b001, 5'd16), "slli_x16", 32'h0000_0050);
    run(i_type(12'h0F0, 5'd6, 3'b111, 5'd17), "andi_x17", 32'h0000_00F0);
    run(i_type(12'hFFF, 5'd1, 3'b011, 5'd20), "sltiu_x20", 32'd1);
    read_reg(5'd11, "rd_x11", 32'hFFFF_FFFD);
    read_reg(5'd12, "rd_x12", 32'h0000_0500);
    read_reg(5'd19, "rd_x19", 32'h07FF_FFFF);

    // Illegal / unsupported encodings must not write
    @(negedge clk);
    instr = 32'h0000_0000;
    push("nop_we", S_WE, 32'd0);
    push("nop_op", S_OP, 32'd0);
    push("nop_imm", S_IMM, 32'd0);
    check_sb(2);
    @(negedge clk);
    instr = r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd1);
    push("mul_we", S_WE, 32'd0);
    check_sb(2);
    @(negedge clk);
    instr = r_type(7'b0100000, 5'd2, 5'd1, 3'b001, 5'd2);
    push("f7_20_sll_we", S_WE, 32'd0);
    check_sb(2);
    read_reg(5'd1, "rd_x1_kept", 32'd5);
    read_reg(5'd2, "rd_x2_kept", 32'd8);

    // Asynchronous reset between edges
    @(negedge clk);
    #1;
    rst = 1'b0;
    instr = r_type(7'b0000000, 5'd0, 5'd1, 3'b000, 5'd0);
    push("areset_x1", S_RS1, 32'd0);
    check_sb(1);
    instr = r_type(7'b0000000, 5'd0, 5'd3, 3'b000, 5'd0);
    push("areset_x3", S_RS1, 32'd0);
    check_sb(1);
    instr = r_type(7'b0000000, 5'd0, 5'd6, 3'b000, 5'd0);
    push("areset_x6", S_RS1, 32'd0);
    check_sb(1);
    @(negedge clk);
    rst = 1'b1;
    instr = i_type(12'd5, 5'd0, 3'b000, 5'd1);
    push("post_reset_addi", S_RES, 32'd5);
    check_sb(2);
    read_reg(5'd1, "post_reset_x1", 32'd5);
    read_reg(5'd2, "post_reset_x2", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
